compare_searcher: RTL and testbench

COMPARE_SEARCHER -- requirements
Module: compare_searcher

---
 rtl/compare_searcher.sv | 164 ++++++++++++++++
 tb/tb_compare_searcher.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/compare_searcher.sv
// Binary searcher that drives a probe to an external comparator and narrows
// [lo, hi] from its gt/lt/eq answers until a match, exhaustion or inconsistency.
module compare_searcher #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       iter_count
);

  localparam int unsigned MAX_ITER = WIDTH + 1;
  localparam logic [4:0]  MAX_ITER_C = 5'(MAX_ITER);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] PROBE0   = ALL_ONES >> 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q, found_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [4:0]       iter_q, iter_d;

  logic [WIDTH:0]   sum_up_c, sum_dn_c;
  logic             term_c;

  // Midpoints use one extra bit so probe+1+hi never loses its carry.
  always_comb begin
    sum_up_c = (WIDTH+1)'(probe_q) + (WIDTH+1)'(1) + (WIDTH+1)'(hi_q);
    sum_dn_c = (WIDTH+1)'(lo_q) + (WIDTH+1)'(probe_q) - (WIDTH+1)'(1);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    probe_d  = probe_q;
    result_d = result_q;
    found_d  = found_q;
    error_d  = error_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    iter_d   = iter_q;
    term_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d  = S_SEARCH;
          lo_d     = '0;
          hi_d     = ALL_ONES;
          probe_d  = PROBE0;
          iter_d   = 5'd0;
          found_d  = 1'b0;
          error_d  = 1'b0;
          result_d = '0;
          busy_d   = 1'b1;
        end
      end
      S_SEARCH: begin
        iter_d = iter_q + 5'd1;
        unique case ({gt, lt, eq})
          3'b001: begin
            result_d = probe_q;
            found_d  = 1'b1;
            term_c   = 1'b1;
          end
          3'b100: begin
            if (probe_q == hi_q) begin
              term_c = 1'b1;
            end else begin
              lo_d    = probe_q + WIDTH'(1);
              probe_d = WIDTH'(sum_up_c >> 1);
            end
          end
          3'b010: begin
            if (probe_q == lo_q) begin
              term_c = 1'b1;
            end else begin
              hi_d    = probe_q - WIDTH'(1);
              probe_d = WIDTH'(sum_dn_c >> 1);
            end
          end
          default: begin
            error_d = 1'b1;
            term_c  = 1'b1;
          end
        endcase
        // Iteration guard catches a comparator that never lets the range close.
        if (!term_c && (iter_d >= MAX_ITER_C)) begin
          error_d = 1'b1;
          term_c  = 1'b1;
        end
        if (term_c) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      probe_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      iter_q   <= 5'd0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      found_q  <= found_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      iter_q   <= iter_d;
    end
  end

  assign probe      = probe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign error      = error_q;
  assign result     = result_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_compare_searcher.sv
// Bench for compare_searcher: comparator model with fault injection, directed
// table, random searches against a range-halving reference, reset and restart cases.
module tb_compare_searcher;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          gt, lt, eq;
  logic [W-1:0]  probe;
  logic          busy, done, found, error;
  logic [W-1:0]  result;
  logic [4:0]    iter_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Comparator environment
  int         hidden  = 0;
  int         mode    = 0;  // 0 honest, 1 always gt, 2 always lt
  int         bad_at  = 0;  // 1-based probe index that gets bad_pat (0 = none)
  logic [2:0] bad_pat = 3'b000;
  int         cur_idx = 0;

  // Reference model outputs
  longint exp_probes[$];
  int     m_iter;
  logic   m_found, m_error;
  longint m_result;

  // Per-run observations
  int     last_cycles;
  longint last_probe;

  always #5 clk = ~clk;

  compare_searcher #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .gt         (gt),
    .lt         (lt),
    .eq         (eq),
    .probe      (probe),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .error      (error),
    .result     (result),
    .iter_count (iter_count)
  );

  always_comb begin
    if (bad_at != 0 && cur_idx == bad_at) begin
      {gt, lt, eq} = bad_pat;
    end else if (mode == 1) begin
      {gt, lt, eq} = 3'b100;
    end else if (mode == 2) begin
      {gt, lt, eq} = 3'b010;
    end else begin
      gt = (hidden > int'(probe));
      lt = (hidden < int'(probe));
      eq = (hidden == int'(probe));
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain interval-halving search over [0, 2^W-1] answering like the environment.
  task automatic model_run(input int hid, input int md, input int ba, input logic [2:0] bp);
    longint lo, hi, p;
    logic [2:0] f;
    bit fin;
    lo = 0;
    hi = (longint'(1) << W) - 1;
    exp_probes.delete();
    m_found = 1'b0;
    m_error = 1'b0;
    m_result = 0;
    m_iter = 0;
    fin = 1'b0;
    while (!fin) begin
      p = (lo + hi) / 2;
      exp_probes.push_back(p);
      m_iter++;
      if (ba != 0 && m_iter == ba) f = bp;
      else if (md == 1) f = 3'b100;
      else if (md == 2) f = 3'b010;
      else f = {longint'(hid) > p, longint'(hid) < p, longint'(hid) == p};
      if (f == 3'b001) begin
        m_found = 1'b1; m_result = p; fin = 1'b1;
      end else if (f == 3'b100) begin
        if (p == hi) fin = 1'b1; else lo = p + 1;
      end else if (f == 3'b010) begin
        if (p == lo) fin = 1'b1; else hi = p - 1;
      end else begin
        m_error = 1'b1; fin = 1'b1;
      end
      if (!fin && m_iter >= int'(W) + 1) begin
        m_error = 1'b1; fin = 1'b1;
      end
    end
  endtask

  // Start a search, follow its probes and check the done handshake.
  task automatic run_search(input int hid, input int md, input int ba,
                            input logic [2:0] bp, input int glitch_at);
    int cyc;
    bit got_done;
    model_run(hid, md, ba, bp);
    hidden = hid; mode = md; bad_at = ba; bad_pat = bp; cur_idx = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 40) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (busy) begin
          cur_idx++;
          if (cur_idx <= exp_probes.size()) chk("probe_seq", longint'(probe), exp_probes[cur_idx-1]);
          else chk("extra_probe", longint'(cur_idx), longint'(exp_probes.size()));
        end
        start = (glitch_at > 0 && cur_idx == glitch_at);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_seen", longint'(got_done), 1);
    chk("search_cycles", longint'(cyc), longint'(exp_probes.size()));
    chk("busy_at_done", longint'(busy), 0);
    last_cycles = cyc;
    last_probe = longint'(probe);
    cur_idx = 0;
    @(negedge clk);
    chk("done_one_cycle", longint'(done), 0);
    chk("busy_idle", longint'(busy), 0);
    chk("probe_held", longint'(probe), last_probe);
  endtask

  typedef struct {
    int         hidden;
    int         mode;
    int         bad_at;
    logic [2:0] bad_pat;
    int         exp_iter;
    logic       exp_found;
    logic       exp_error;
    int         exp_result;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32767, 0, 0, 3'b000,  1, 1'b1, 1'b0, 32767};
    vecs[1] = '{    0, 0, 0, 3'b000, 16, 1'b1, 1'b0,     0};
    vecs[2] = '{65535, 0, 0, 3'b000, 17, 1'b1, 1'b0, 65535};
    vecs[3] = '{ 1000, 0, 3, 3'b110,  3, 1'b0, 1'b1,     0};
    vecs[4] = '{    0, 1, 0, 3'b000, 17, 1'b0, 1'b0,     0};
    vecs[5] = '{    0, 2, 0, 3'b000, 16, 1'b0, 1'b0,     0};
    vecs[6] = '{ 1234, 0, 1, 3'b000,  1, 1'b0, 1'b1,     0};
    vecs[7] = '{50000, 0, 5, 3'b101,  5, 1'b0, 1'b1,     0};

    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_probe", longint'(probe), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_found", longint'(found), 0);
    chk("rst_error", longint'(error), 0);
    chk("rst_result", longint'(result), 0);
    chk("rst_iter", longint'(iter_count), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_search(vecs[i].hidden, vecs[i].mode, vecs[i].bad_at, vecs[i].bad_pat, 0);
      chk($sformatf("vec%0d_iter", i), longint'(iter_count), longint'(vecs[i].exp_iter));
      chk($sformatf("vec%0d_found", i), longint'(found), longint'(vecs[i].exp_found));
      chk($sformatf("vec%0d_error", i), longint'(error), longint'(vecs[i].exp_error));
      chk($sformatf("vec%0d_result", i), longint'(result), longint'(vecs[i].exp_result));
    end

    // start pulsed mid-search must not disturb the outcome
    run_search(12345, 0, 0, 3'b000, 3);
    chk("glitch_iter", longint'(iter_count), longint'(m_iter));
    chk("glitch_found", longint'(found), 1);
    chk("glitch_result", longint'(result), 12345);

    // reset at iteration 5 aborts without a done pulse
    hidden = 40000; mode = 0; bad_at = 0; cur_idx = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 5; k++) @(negedge clk);
    chk("pre_rst_busy", longint'(busy), 1);
    chk("pre_rst_iter", longint'(iter_count), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_probe", longint'(probe), 0);
    chk("abort_iter", longint'(iter_count), 0);
    chk("abort_found", longint'(found), 0);
    chk("abort_error", longint'(error), 0);
    chk("abort_result", longint'(result), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", longint'(done), 0);
      chk("abort_stay_idle", longint'(busy), 0);
    end
    run_search(40000, 0, 0, 3'b000, 0);
    chk("restart_found", longint'(found), 1);
    chk("restart_result", longint'(result), 40000);
    chk("restart_iter", longint'(iter_count), longint'(m_iter));

    // random searches, some with an injected inconsistent answer
    for (int r = 0; r < 30; r++) begin
      int hid, ba;
      logic [2:0] bp;
      logic [2:0] pats [5];
      pats = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
      hid = int'($urandom_range(0, 65535));
      ba = 0;
      bp = 3'b000;
      if ($urandom_range(0, 3) == 0) begin
        ba = int'($urandom_range(1, 8));
        bp = pats[$urandom_range(0, 4)];
      end
      run_search(hid, 0, ba, bp, 0);
      chk("rnd_iter", longint'(iter_count), longint'(m_iter));
      chk("rnd_found", longint'(found), longint'(m_found));
      chk("rnd_error", longint'(error), longint'(m_error));
      chk("rnd_result", longint'(result), m_result);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
